// File: rtl/rr_req_agent.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_req_agent : per-channel job queue that drives requests to an arbiter,
//                counts served jobs and flags protocol errors and starvation.
// Revision     : 1.0
// ---------------------------------------------------------------------------
module rr_req_agent #(
  parameter int N          = 4,
  parameter int DEPTH_W    = 4,
  parameter int STARVE_MAX = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         push_i,
  input  logic                 flush_i,
  input  logic [N-1:0]         grant_i,
  output logic [N-1:0]         req_o,
  output logic [15:0]          served_cnt_o,
  output logic                 err_onehot_o,
  output logic                 err_spurious_o,
  output logic                 err_ovf_o,
  output logic                 err_starve_o,
  output logic [$clog2(N)-1:0] starve_id_o
);

  localparam int ID_W = $clog2(N);
  localparam int WC_W = $clog2(STARVE_MAX + 1);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_IDLE  = 2'd2;

  localparam logic [DEPTH_W-1:0] PEND_MAX = {DEPTH_W{1'b1}};
  localparam logic [WC_W-1:0]    WC_MAX   = WC_W'(STARVE_MAX);

  logic [1:0]      state_q, state_d;
  logic [N-1:0]    req_q, req_d;
  logic [N-1:0]    serve, ovf_hit, starve_hit;
  logic [15:0]     served_cnt_q, served_cnt_d, serve_num;
  logic            onehot_q, spur_q, ovf_q, starve_q;
  logic [ID_W-1:0] starve_id_q, starve_pick;

  // req_q is only ever set when the next state is RUN, so this excludes
  // grants arriving in FLUSH/IDLE as well.
  assign serve = grant_i & req_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (flush_i)  state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_IDLE;
      ST_IDLE:  if (!flush_i) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_chan
    logic [DEPTH_W-1:0] pend_q, pend_d;
    logic [WC_W-1:0]    wcnt_q, wcnt_d;

    always_comb begin
      pend_d = pend_q;
      if (state_q == ST_FLUSH) begin
        pend_d = '0;
      end else if (push_i[gi] && !serve[gi]) begin
        if (pend_q != PEND_MAX) pend_d = pend_q + DEPTH_W'(1);
      end else if (!push_i[gi] && serve[gi]) begin
        pend_d = pend_q - DEPTH_W'(1);
      end
    end

    always_comb begin
      wcnt_d = wcnt_q;
      if (state_q == ST_FLUSH || !req_q[gi] || serve[gi]) begin
        wcnt_d = '0;
      end else if (wcnt_q != WC_MAX) begin
        wcnt_d = wcnt_q + WC_W'(1);
      end
    end

    assign ovf_hit[gi]    = (state_q != ST_FLUSH) && push_i[gi] && !serve[gi] &&
                            (pend_q == PEND_MAX);
    assign starve_hit[gi] = (wcnt_d == WC_MAX);
    assign req_d[gi]      = (state_d == ST_RUN) && (pend_d != '0);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pend_q <= '0;
        wcnt_q <= '0;
      end else begin
        pend_q <= pend_d;
        wcnt_q <= wcnt_d;
      end
    end
  end

  always_comb begin
    serve_num = '0;
    for (int i = 0; i < N; i++) serve_num = serve_num + 16'(serve[i]);
    served_cnt_d = served_cnt_q + serve_num;
    starve_pick  = '0;
    // Descending scan so the lowest starving index wins.
    for (int i = N - 1; i >= 0; i--) begin
      if (starve_hit[i]) starve_pick = ID_W'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      req_q        <= '0;
      served_cnt_q <= '0;
      onehot_q     <= 1'b0;
      spur_q       <= 1'b0;
      ovf_q        <= 1'b0;
      starve_q     <= 1'b0;
      starve_id_q  <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      served_cnt_q <= served_cnt_d;
      if ((grant_i & (grant_i - N'(1))) != '0) onehot_q <= 1'b1;
      if ((grant_i & ~req_q) != '0)            spur_q   <= 1'b1;
      if (ovf_hit != '0)                       ovf_q    <= 1'b1;
      if (!starve_q && (starve_hit != '0)) begin
        starve_q    <= 1'b1;
        starve_id_q <= starve_pick;
      end
    end
  end

  assign req_o          = req_q;
  assign served_cnt_o   = served_cnt_q;
  assign err_onehot_o   = onehot_q;
  assign err_spurious_o = spur_q;
  assign err_ovf_o      = ovf_q;
  assign err_starve_o   = starve_q;
  assign starve_id_o    = starve_id_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_req_agent.sv
`default_nettype none
// tb_rr_req_agent : directed vector table, corner sequences and random stimulus
// compared against a queue-level reference model of the request agent.
module tb_rr_req_agent;

  localparam int N      = 4;
  localparam int PMAX   = 15;
  localparam int STARVE = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] push_i, grant_i;
  logic         flush_i;
  logic [N-1:0] req_o;
  logic [15:0]  served_cnt_o;
  logic         err_onehot_o, err_spurious_o, err_ovf_o, err_starve_o;
  logic [1:0]   starve_id_o;

  int checks = 0;
  int errors = 0;

  rr_req_agent #(.N(N), .DEPTH_W(4), .STARVE_MAX(STARVE)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .push_i        (push_i),
    .flush_i       (flush_i),
    .grant_i       (grant_i),
    .req_o         (req_o),
    .served_cnt_o  (served_cnt_o),
    .err_onehot_o  (err_onehot_o),
    .err_spurious_o(err_spurious_o),
    .err_ovf_o     (err_ovf_o),
    .err_starve_o  (err_starve_o),
    .starve_id_o   (starve_id_o)
  );

  always #5 clk = ~clk;

  // Reference model: job counts per channel, waiting time per channel, mode.
  typedef enum int {M_RUN, M_FLUSH, M_IDLE} mode_t;
  int           m_pend[N];
  int           m_wait[N];
  mode_t        m_mode;
  logic [N-1:0] m_req;
  int           m_served;
  bit           m_onehot, m_spur, m_ovf, m_starve;
  int           m_id;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin m_pend[i] = 0; m_wait[i] = 0; end
    m_mode = M_RUN; m_req = '0; m_served = 0;
    m_onehot = 0; m_spur = 0; m_ovf = 0; m_starve = 0; m_id = 0;
  endtask

  task automatic model_step(input logic [N-1:0] p, input logic f, input logic [N-1:0] g);
    logic [N-1:0] srv;
    mode_t        nxt;
    bit           found;
    srv = g & m_req;
    if ($countones(g) > 1) m_onehot = 1;
    if ((g & ~m_req) != 0) m_spur = 1;
    m_served = (m_served + $countones(srv)) % 65536;
    case (m_mode)
      M_RUN:   nxt = f ? M_FLUSH : M_RUN;
      M_FLUSH: nxt = M_IDLE;
      default: nxt = f ? M_IDLE : M_RUN;
    endcase
    for (int i = 0; i < N; i++) begin
      if (m_mode == M_FLUSH) begin
        m_pend[i] = 0; m_wait[i] = 0;
      end else begin
        int np;
        np = m_pend[i] + int'(p[i]) - int'(srv[i]);
        if (np > PMAX) begin np = PMAX; m_ovf = 1; end
        m_pend[i] = np;
        if (!m_req[i] || srv[i]) m_wait[i] = 0;
        else if (m_wait[i] < STARVE) m_wait[i] = m_wait[i] + 1;
      end
    end
    found = 0;
    for (int i = 0; i < N; i++) begin
      if (!m_starve && !found && m_wait[i] == STARVE) begin
        found = 1; m_starve = 1; m_id = i;
      end
    end
    m_mode = nxt;
    for (int i = 0; i < N; i++) m_req[i] = (nxt == M_RUN) && (m_pend[i] > 0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_req"},    32'(req_o),          32'(m_req));
    chk({tag, "_served"}, 32'(served_cnt_o),   32'(m_served));
    chk({tag, "_onehot"}, 32'(err_onehot_o),   32'(m_onehot));
    chk({tag, "_spur"},   32'(err_spurious_o), 32'(m_spur));
    chk({tag, "_ovf"},    32'(err_ovf_o),      32'(m_ovf));
    chk({tag, "_starve"}, 32'(err_starve_o),   32'(m_starve));
    chk({tag, "_id"},     32'(starve_id_o),    32'(m_id));
  endtask

  // Inputs change at posedge+1; outputs are sampled at the following posedge+1.
  task automatic step(input logic [N-1:0] p, input logic f, input logic [N-1:0] g);
    push_i = p; flush_i = f; grant_i = g;
    model_step(p, f, g);
    @(posedge clk); #1;
    check_model("model");
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step('0, 1'b0, '0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; #1;
    chk("rst_req",    32'(req_o), 0);
    chk("rst_served", 32'(served_cnt_o), 0);
    chk("rst_errs",   32'({err_starve_o, err_ovf_o, err_spurious_o, err_onehot_o}), 0);
    chk("rst_id",     32'(starve_id_o), 0);
    push_i = '1; grant_i = '1; flush_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [N-1:0] push;
    logic         flush;
    logic [N-1:0] grant;
    logic [N-1:0] exp_req;
    logic [15:0]  exp_served;
    logic [3:0]   exp_err;   // {starve, ovf, spurious, onehot}
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{4'b0101, 1'b0, 4'b0000, 4'b0101, 16'd0, 4'b0000};
    vecs[1] = '{4'b0010, 1'b0, 4'b0000, 4'b0111, 16'd0, 4'b0000};
    vecs[2] = '{4'b0010, 1'b0, 4'b0000, 4'b0111, 16'd0, 4'b0000};
    vecs[3] = '{4'b0010, 1'b0, 4'b0000, 4'b0111, 16'd0, 4'b0000};
    vecs[4] = '{4'b0000, 1'b0, 4'b0010, 4'b0111, 16'd1, 4'b0000};
    vecs[5] = '{4'b0000, 1'b0, 4'b0010, 4'b0111, 16'd2, 4'b0000};
    vecs[6] = '{4'b0000, 1'b0, 4'b0010, 4'b0101, 16'd3, 4'b0000};
    vecs[7] = '{4'b0000, 1'b0, 4'b0101, 4'b0000, 16'd5, 4'b0001};
    vecs[8] = '{4'b0000, 1'b0, 4'b1000, 4'b0000, 16'd5, 4'b0011};

    rst_n = 1'b0; push_i = '0; flush_i = 1'b0; grant_i = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("init_req",    32'(req_o), 0);
    chk("init_served", 32'(served_cnt_o), 0);
    chk("init_errs",   32'({err_starve_o, err_ovf_o, err_spurious_o, err_onehot_o}), 0);
    rst_n = 1'b1;

    for (int k = 0; k < 9; k++) begin
      step(vecs[k].push, vecs[k].flush, vecs[k].grant);
      chk($sformatf("vec%0d_req", k),    32'(req_o),        32'(vecs[k].exp_req));
      chk($sformatf("vec%0d_served", k), 32'(served_cnt_o), 32'(vecs[k].exp_served));
      chk($sformatf("vec%0d_err", k),
          32'({err_starve_o, err_ovf_o, err_spurious_o, err_onehot_o}), 32'(vecs[k].exp_err));
    end

    // Starvation on channel 2 after exactly 16 unserved request cycles.
    step(4'b0100, 1'b0, '0);
    idle(15);
    chk("starve_before", 32'(err_starve_o), 0);
    idle(1);
    chk("starve_set", 32'(err_starve_o), 1);
    chk("starve_id2", 32'(starve_id_o), 2);
    step('0, 1'b0, 4'b0100);
    chk("starve_served", 32'(served_cnt_o), 6);
    chk("starve_req_off", 32'(req_o), 0);
    step(4'b0001, 1'b0, '0);
    idle(18);
    chk("starve_id_frozen", 32'(starve_id_o), 2);
    step('0, 1'b0, 4'b0001);

    // Overflow on channel 3: 15 pushes fill it, the 16th overflows.
    for (int k = 0; k < 15; k++) step(4'b1000, 1'b0, '0);
    chk("ovf_before", 32'(err_ovf_o), 0);
    step(4'b1000, 1'b0, '0);
    chk("ovf_set", 32'(err_ovf_o), 1);
    chk("ovf_req", 32'(req_o), 4'b1000);

    // Flush with everything pending, then accumulate in IDLE.
    step(4'b1111, 1'b0, '0);
    chk("pre_flush_req", 32'(req_o), 4'b1111);
    step('0, 1'b1, '0);
    chk("flush_req", 32'(req_o), 0);
    step(4'b0010, 1'b0, '0);
    chk("flush_state_req", 32'(req_o), 0);
    step(4'b0001, 1'b1, '0);
    chk("idle_req", 32'(req_o), 0);
    step('0, 1'b0, '0);
    chk("resume_req", 32'(req_o), 4'b0001);

    // Random segments, each starting with a mid-operation asynchronous reset.
    for (int seg = 0; seg < 4; seg++) begin
      do_reset();
      for (int c = 0; c < 500; c++) begin
        logic [N-1:0] p, g;
        logic         f;
        int           r;
        p = '0;
        for (int i = 0; i < N; i++) p[i] = ($urandom_range(0, 3) == 0);
        f = ($urandom_range(0, 49) == 0);
        r = $urandom_range(0, 99);
        g = '0;
        if (r < 50 + seg * 10 && m_req != 0) begin
          int b;
          b = $urandom_range(0, N - 1);
          while (!m_req[b]) b = (b + 1) % N;
          g[b] = 1'b1;
        end else if (r >= 95 - seg) begin
          g = N'($urandom_range(0, 15));
        end
        step(p, f, g);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rr_req_agent.md
RR_REQ_AGENT -- requirements
Module: rr_req_agent

Interface
REQ-001 Parameter N, default 4: number of request channels; legal range 2..16.
REQ-002 Parameter DEPTH_W, default 4: width of each per-channel pending-job counter; maximum count is 2**DEPTH_W-1.
REQ-003 Parameter STARVE_MAX, default 16: number of consecutive unserved request cycles that flags starvation.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 push  input  N  per-channel job enqueue strobe; each asserted bit adds one job in that cycle.
REQ-007 flush  input  1  synchronous command that drops all pending jobs.
REQ-008 req  output  N  request vector to the arbiter; req[i]=1 while channel i has pending jobs and the agent is in RUN.
REQ-009 grant  input  N  registered grant vector from the arbiter; sampled on the rising edge.
REQ-010 served_cnt  output  16  total jobs served, wraps modulo 2**16.
REQ-011 err_onehot  output  1  sticky flag: grant had more than one bit set.
REQ-012 err_spurious  output  1  sticky flag: grant[i]=1 while req[i]=0.
REQ-013 err_ovf  output  1  sticky flag: push to a full channel.
REQ-014 err_starve  output  1  sticky flag: a channel waited STARVE_MAX cycles.
REQ-015 starve_id  output  $clog2(N)  index of the first channel that starved; frozen once err_starve is set.

Function
REQ-016 Per channel i, pend[i] (DEPTH_W bits): the update each cycle is +push[i] and -(grant[i]&req[i]); simultaneous push and serve leave pend[i] unchanged.
REQ-017 A push to pend[i] = max with no serve in the same cycle leaves pend[i] at max and sets err_ovf; a push with a serve in the same cycle is legal.
REQ-018 req[i] is a register output equal to (pend_next[i]!=0) in RUN; a job served on the last pending entry deasserts req[i] on the following cycle.
REQ-019 A grant is a valid serve only when grant[i]=1 and req[i]=1 at the same sampling edge; served_cnt increments by popcount(grant&req) each cycle.
REQ-020 grant with popcount>1 sets err_onehot; every set bit that is also requesting still counts as served.
REQ-021 grant[i]=1 with req[i]=0 sets err_spurious and changes neither pend nor served_cnt.
REQ-022 Per-channel wait counter wcnt[i]: cleared when req[i]=0 or a valid serve of channel i occurs; otherwise increments and saturates at STARVE_MAX.
REQ-023 When wcnt[i] reaches STARVE_MAX and err_starve=0, set err_starve and load starve_id=i; ties between channels resolve to the lowest index.
REQ-024 Control FSM states are RUN, FLUSH and IDLE.
REQ-025 FSM transitions: RUN->FLUSH on flush=1; FLUSH->IDLE after one cycle; IDLE->RUN on the first cycle with flush=0.
REQ-026 In FLUSH, all pend and wcnt are cleared and req=0; push is ignored in FLUSH.
REQ-027 In IDLE, req=0 and push accumulates into pend, so that req resumes on return to RUN.
REQ-028 Grants received while not in RUN set err_spurious.
REQ-029 Error flags stay set until reset; no software clear is provided.

Reset
REQ-030 While rst_n=0: req=0, all pend=0, all wcnt=0, served_cnt=0, every err flag=0, starve_id=0, FSM=RUN.
REQ-031 Asynchronous assertion mid-operation takes effect immediately; no grant or push is sampled until the first edge after deassertion.

Verification
REQ-032 Reset, then push=4'b0101 for 1 cycle and grant=0 -> req=4'b0101 next cycle; pend[0]=pend[2]=1.
REQ-033 Push channel 1 three times, then grant=4'b0010 for 3 cycles -> served_cnt=3; req[1] falls the cycle after the third grant; no error flags.
REQ-034 Push channel 3 sixteen times with DEPTH_W=4 and no grant -> pend[3]=15, err_ovf=1 on the 16th push.
REQ-035 req=4'b0011 held with grant=4'b0011 for 1 cycle -> err_onehot=1, served_cnt+=2; grant=4'b1000 with req[3]=0 -> err_spurious=1, counts unchanged.
REQ-036 Push channel 2 once and never grant it for 16 cycles -> err_starve=1, starve_id=2; a later starve on channel 0 leaves starve_id=2.
REQ-037 Pending on all channels, assert flush for 1 cycle -> req=0 within 1 cycle, pend cleared; push channel 0 in IDLE, drop flush -> req=4'b0001 after return to RUN.
